seg7_decode: RTL
================

# seg7_decode

Segment-pattern decoder and change monitor: samples an active-low 7-bit seven-segment bus (`seg[6:0]` = g..a, 0 = lit), waits for the pattern to be stable, then decodes it back to a hex nibble with blank and illegal flags. Each decoded result is handed out once over a valid/ready interface. It is the receive end of the hex-to-segment encoding used on the DE1-SoC HEX displays. It is used in self-checking lab top levels and benches to read back what a display driver is actually showing.

## Interface
- `STABLE_CYCLES`, default 4 (legal range 1..255): number of consecutive identical samples required before a commit.
- `clk`  in  1: single clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `seg`  in  7: active-low segment pattern, bit 0 = a … bit 6 = g.
- `out_valid`  out  1: a decoded result is pending.
- `out_ready`  in  1: consumer accepts the result when it is high together with `out_valid` at a rising edge.
- `out_val`  out  4: decoded hex value; 0 when blank or illegal.
- `out_blank`  out  1: the committed pattern was 7'h7F (all segments off).
- `out_illegal`  out  1: the committed pattern is neither a hex glyph nor blank.
- `overrun`  out  1: one-cycle pulse when a pending result is overwritten.
- `err_count`  out  8: saturating count of illegal commits. Reads 0 when the feature is compiled out.

## Operation
- Glyph table:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - 1111111 = blank. Every other code is illegal.
- Sampler: `seg` is registered every edge. A run counter resets to 1 whenever the new sample differs from the previous sample. Otherwise it increments, saturating at `STABLE_CYCLES`.
- Commit: fires when the run counter reaches `STABLE_CYCLES` and the stable pattern differs from the last committed pattern. After reset there is no last pattern, so the first stable pattern always commits, including blank.
- Commit effects: load `out_val`, `out_blank` and `out_illegal` from the glyph table, set `out_valid`, and record the pattern as last committed.
- FSM, output side:
  - IDLE → PEND on a commit.
  - PEND → IDLE on accept with no commit in the same cycle.
  - PEND stays PEND on commit-with-accept: the old result is consumed, the new one is loaded, and there is no overrun.
  - PEND stays PEND on commit-without-accept: the result registers are overwritten (last-wins) and `overrun` pulses.
- Output registers are held while in PEND without a commit.
- A pattern that is held unchanged produces exactly one commit, regardless of duration.
- A pattern that changes back (A → B → A) produces a new commit for A once B has itself committed. If B was not stable long enough to commit, A does not recommit.

## Timing
- Reset values: `out_valid`=0, `out_val`=0, `out_blank`=0, `out_illegal`=0, `overrun`=0, `err_count`=0. The run counter and the last-committed record are cleared.
- Latency: if a pattern is first sampled at edge k and held, `out_valid` goes high after edge k+STABLE_CYCLES−1. For `STABLE_CYCLES`=1, the commit occurs on the edge that samples the pattern.
- Reset asserted mid-run or while in PEND: all state clears immediately (asynchronous), and any pending result is lost. After release, sampling restarts from zero.
- `overrun` is high for exactly one cycle per overwrite event.
- There are no combinational paths from `seg` or `out_ready` to any output.

## Configuration
- Macro: `SEG7_DECODE_ERRCNT_EN`.
- Defined: `err_count` increments by 1 on each illegal commit and saturates at 255. It is cleared only by reset.
- Undefined: the counter logic is removed and `err_count` is tied to 8'd0. All other behaviour is identical.

## Test plan
1. Reset. Hold `seg`=0100100 with `out_ready`=1 → `out_valid` high for one cycle at edge k+3 with `out_val`=2, `out_blank`=0, `out_illegal`=0.
2. Glitch rejection: apply 1111001 for 3 cycles, then hold 0110000 → no commit for 1. A single commit occurs with `out_val`=3.
3. Hold 0001110 for 100 cycles with `out_ready`=1 → exactly one commit, `out_val`=F. Then hold 1111111 → one commit with `out_blank`=1 and `out_val`=0.
4. Backpressure: with `out_ready`=0, commit 0000000, then commit 0001000 → `overrun` pulses once and `out_val` becomes A. Raising `out_ready` → one accept, then `out_valid`=0.
5. Illegal pattern: hold 1111110 → `out_illegal`=1, `out_val`=0. `err_count` reads 1 with the macro and 0 without. Alternating 300 illegal and legal commits saturates `err_count` at 255.
6. Mid-operation reset: pulse `rst_n` low while in PEND → all outputs read 0 immediately. The same stable pattern then recommits STABLE_CYCLES edges after release.

Source files
------------

// File: rtl/seg7_decode.sv
// Seven-segment read-back: debounces an active-low segment bus, decodes committed
// patterns to a hex nibble over valid/ready. Optional SEG7_DECODE_ERRCNT_EN adds an illegal-commit counter.
module seg7_decode #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_val,
    output logic       out_blank,
    output logic       out_illegal,
    output logic       overrun,
    output logic [7:0] err_count
);

    localparam int unsigned SEG_W = 7;
    localparam int unsigned VAL_W = 4;
    localparam int unsigned RUN_W = 8;
    localparam int unsigned ERR_W = 8;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_e;

    typedef struct packed {
        logic             illegal;
        logic             blank;
        logic [VAL_W-1:0] val;
    } dec_t;

    // Glyph table lookup; anything not a hex glyph or blank is illegal.
    function automatic dec_t decode(input logic [SEG_W-1:0] p);
        dec_t d;
        d = '{illegal: 1'b0, blank: 1'b0, val: 4'h0};
        case (p)
            7'b1000000: d.val = 4'h0;
            7'b1111001: d.val = 4'h1;
            7'b0100100: d.val = 4'h2;
            7'b0110000: d.val = 4'h3;
            7'b0011001: d.val = 4'h4;
            7'b0010010: d.val = 4'h5;
            7'b0000010: d.val = 4'h6;
            7'b1111000: d.val = 4'h7;
            7'b0000000: d.val = 4'h8;
            7'b0010000: d.val = 4'h9;
            7'b0001000: d.val = 4'hA;
            7'b0000011: d.val = 4'hB;
            7'b1000110: d.val = 4'hC;
            7'b0100001: d.val = 4'hD;
            7'b0000110: d.val = 4'hE;
            7'b0001110: d.val = 4'hF;
            7'b1111111: d.blank = 1'b1;
            default:    d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    state_e           state_q, state_d;
    logic [SEG_W-1:0] samp_q, samp_d;
    logic             have_samp_q, have_samp_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [SEG_W-1:0] last_q, last_d;
    logic             have_last_q, have_last_d;
    logic [VAL_W-1:0] val_q, val_d;
    logic             blank_q, blank_d;
    logic             illegal_q, illegal_d;
    logic             overrun_q, overrun_d;
    logic             commit_c;
    dec_t             dec_c;

    // Sampler, run counter and commit detection.
    always_comb begin
        samp_d      = seg;
        have_samp_d = 1'b1;
        run_d       = RUN_W'(1);
        if (have_samp_q && (seg == samp_q)) begin
            run_d = (run_q >= RUN_MAX) ? RUN_MAX : run_q + RUN_W'(1);
        end
        commit_c = (run_d == RUN_MAX) && (!have_last_q || (seg != last_q));
        dec_c    = decode(seg);
    end

    // Output-side FSM and result registers.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        have_last_d = have_last_q;
        val_d       = val_q;
        blank_d     = blank_q;
        illegal_d   = illegal_q;
        overrun_d   = 1'b0;
        if (commit_c) begin
            last_d      = seg;
            have_last_d = 1'b1;
            val_d       = dec_c.val;
            blank_d     = dec_c.blank;
            illegal_d   = dec_c.illegal;
        end
        case (state_q)
            IDLE: begin
                if (commit_c) state_d = PEND;
            end
            PEND: begin
                if (commit_c) begin
                    overrun_d = !out_ready;
                end else if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            samp_q      <= '0;
            have_samp_q <= 1'b0;
            run_q       <= '0;
            last_q      <= '0;
            have_last_q <= 1'b0;
            val_q       <= '0;
            blank_q     <= 1'b0;
            illegal_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            samp_q      <= samp_d;
            have_samp_q <= have_samp_d;
            run_q       <= run_d;
            last_q      <= last_d;
            have_last_q <= have_last_d;
            val_q       <= val_d;
            blank_q     <= blank_d;
            illegal_q   <= illegal_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef SEG7_DECODE_ERRCNT_EN
    logic [ERR_W-1:0] err_q, err_d;

    // Saturating count of illegal commits.
    always_comb begin
        err_d = err_q;
        if (commit_c && dec_c.illegal && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= '0;
        else        err_q <= err_d;
    end

    assign err_count = err_q;
`else
    assign err_count = ERR_W'(0);
`endif

    assign out_valid   = (state_q == PEND);
    assign out_val     = val_q;
    assign out_blank   = blank_q;
    assign out_illegal = illegal_q;
    assign overrun     = overrun_q;

endmodule
